// File: rtl/reorder_buffer_if.sv
// Bundle of dispatch, writeback, rollback, commit and status signals
// between the back-end control logic and the reorder buffer.
//
// Handshake semantics: alloc_valid is a request that the buffer takes
// in the same cycle iff !ROB_full && !rollback (no separate ready; the
// requester sees alloc_tag before the edge and must re-present a refused
// request). wb_valid and rollback are one-cycle strobes with no
// backpressure. commit_valid has no ready: a commit is always consumed
// by the rename/free-list logic in the cycle it is shown.
interface reorder_buffer_if #(
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
);
    logic              alloc_valid;
    logic [4:0]        alloc_arch_rd;
    logic [PREG_W-1:0] alloc_pdst;
    logic [PREG_W-1:0] alloc_old_pdst;
    logic              alloc_wen;
    logic [31:0]       alloc_pc;
    logic [IDX_W-1:0]  alloc_tag;
    logic              ROB_full;
    logic              ROB_empty;
    logic [IDX_W:0]    count;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_tag;
    logic              rollback;
    logic [IDX_W-1:0]  rollback_tag;
    logic              commit_valid;
    logic [4:0]        commit_arch_rd;
    logic [PREG_W-1:0] commit_pdst;
    logic [PREG_W-1:0] commit_old_pdst;
    logic              commit_wen;
    logic [31:0]       commit_pc;

    modport master (
        output alloc_valid, alloc_arch_rd, alloc_pdst, alloc_old_pdst,
               alloc_wen, alloc_pc, wb_valid, wb_tag, rollback, rollback_tag,
        input  alloc_tag, ROB_full, ROB_empty, count, commit_valid,
               commit_arch_rd, commit_pdst, commit_old_pdst, commit_wen,
               commit_pc
    );

    modport slave (
        input  alloc_valid, alloc_arch_rd, alloc_pdst, alloc_old_pdst,
               alloc_wen, alloc_pc, wb_valid, wb_tag, rollback, rollback_tag,
        output alloc_tag, ROB_full, ROB_empty, count, commit_valid,
               commit_arch_rd, commit_pdst, commit_old_pdst, commit_wen,
               commit_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Entries are allocated at the tail,
// marked done from the writeback bus, retired in order from the head and
// trimmed back to a mispredicted branch on rollback.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    reorder_buffer_if.slave  rob
);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    // Pointers carry a wrap bit above the index so full and empty differ.
    logic [PTR_W-1:0]  head, tail;
    logic [IDX_W-1:0]  head_idx, tail_idx;

    logic [DEPTH-1:0]  ent_valid, ent_done;
    logic [4:0]        ent_arch_rd  [DEPTH];
    logic [PREG_W-1:0] ent_pdst     [DEPTH];
    logic [PREG_W-1:0] ent_old_pdst [DEPTH];
    logic              ent_wen      [DEPTH];
    logic [31:0]       ent_pc       [DEPTH];

    logic              full;
    logic              commit_fire;
    logic              alloc_fire;
    logic              rb_fire;
    logic              wb_fire;
    logic [IDX_W-1:0]  rb_dist;
    logic [PTR_W-1:0]  keep;
    logic [DEPTH-1:0]  flush;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // Status is derived from registered pointers only.
    assign rob.count     = tail - head;
    assign full          = (rob.count == FULL_CNT);
    assign rob.ROB_full  = full;
    assign rob.ROB_empty = (rob.count == '0);
    assign rob.alloc_tag = tail_idx;

    // The head retires once its result has been written back.
    assign commit_fire         = ent_valid[head_idx] && ent_done[head_idx];
    assign rob.commit_valid    = commit_fire;
    assign rob.commit_arch_rd  = commit_fire ? ent_arch_rd[head_idx]  : '0;
    assign rob.commit_pdst     = commit_fire ? ent_pdst[head_idx]     : '0;
    assign rob.commit_old_pdst = commit_fire ? ent_old_pdst[head_idx] : '0;
    assign rob.commit_wen      = commit_fire ? ent_wen[head_idx]      : 1'b0;
    assign rob.commit_pc       = commit_fire ? ent_pc[head_idx]       : '0;

    // Any rollback strobe blocks dispatch, even one naming a dead entry.
    assign alloc_fire = rob.alloc_valid && !full && !rob.rollback;
    assign rb_fire    = rob.rollback && ent_valid[rob.rollback_tag];

    // Entries kept on rollback: head through the branch inclusive.
    assign rb_dist = rob.rollback_tag - head_idx;
    assign keep    = PTR_W'(rb_dist) + PTR_W'(1);

    // Mark every slot whose age offset from head lies beyond the branch.
    always_comb begin
        flush = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flush[i] = rb_fire && ((IDX_W'(i) - head_idx) > rb_dist);
        end
    end

    assign wb_fire = rob.wb_valid && ent_valid[rob.wb_tag] && !flush[rob.wb_tag];

    // Head advances on commit; tail advances on alloc or snaps back on rollback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (commit_fire) head <= head + PTR_W'(1);
            if (rb_fire)         tail <= head + keep;
            else if (alloc_fire) tail <= tail + PTR_W'(1);
        end
    end

    // Per-entry valid/done; later assignments (flush, commit) take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire && tail_idx == IDX_W'(i)) begin
                    ent_valid[i] <= 1'b1;
                    ent_done[i]  <= 1'b0;
                end
                if (wb_fire && rob.wb_tag == IDX_W'(i)) ent_done[i] <= 1'b1;
                if (flush[i] || (commit_fire && head_idx == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b0;
                    ent_done[i]  <= 1'b0;
                end
            end
        end
    end

    // Payload is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_arch_rd[tail_idx]  <= rob.alloc_arch_rd;
            ent_pdst[tail_idx]     <= rob.alloc_pdst;
            ent_old_pdst[tail_idx] <= rob.alloc_old_pdst;
            ent_wen[tail_idx]      <= rob.alloc_wen;
            ent_pc[tail_idx]       <= rob.alloc_pc;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order queue model.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    reorder_buffer_if #(.IDX_W(4), .PREG_W(6)) rif();

    reorder_buffer #(.DEPTH(16), .IDX_W(4), .PREG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  rd;
        logic [5:0]  pdst;
        logic [5:0]  old;
        logic        wen;
        logic [31:0] pc;
        bit          done;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    int          seq;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] commit_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_pos(input logic [3:0] t);
        foreach (mq[k]) if (mq[k].idx == t) return k;
        return -1;
    endfunction

    task automatic drive_alloc(input bit v);
        rif.alloc_valid    = v;
        rif.alloc_arch_rd  = 5'(seq + 1);
        rif.alloc_pdst     = 6'(seq);
        rif.alloc_old_pdst = 6'(seq + 7);
        rif.alloc_wen      = ~seq[0];
        rif.alloc_pc       = 32'h1000 + 32'(4 * seq);
        if (v) seq++;
    endtask

    task automatic idle_inputs();
        rif.alloc_valid = 1'b0;
        rif.wb_valid    = 1'b0;
        rif.wb_tag      = '0;
        rif.rollback    = 1'b0;
        rif.rollback_tag = '0;
    endtask

    // Compare the DUT against the model, advance the model, then clock.
    task automatic tick();
        bit   exp_cv;
        bit   do_alloc;
        int   rb_pos;
        int   wb_pos;
        ent_t e;
        exp_cv = (mq.size() > 0) && mq[0].done;
        check("count", 32'(rif.count), 32'(mq.size()));
        check("full", 32'(rif.ROB_full), 32'(mq.size() == 16));
        check("empty", 32'(rif.ROB_empty), 32'(mq.size() == 0));
        check("alloc_tag", 32'(rif.alloc_tag), 32'(m_tail));
        check("commit_valid", 32'(rif.commit_valid), 32'(exp_cv));
        check("commit_arch_rd", 32'(rif.commit_arch_rd), exp_cv ? 32'(mq[0].rd) : 32'd0);
        check("commit_pdst", 32'(rif.commit_pdst), exp_cv ? 32'(mq[0].pdst) : 32'd0);
        check("commit_old_pdst", 32'(rif.commit_old_pdst), exp_cv ? 32'(mq[0].old) : 32'd0);
        check("commit_wen", 32'(rif.commit_wen), exp_cv ? 32'(mq[0].wen) : 32'd0);
        check("commit_pc", rif.commit_pc, exp_cv ? mq[0].pc : 32'd0);
        if (rif.commit_valid) commit_log.push_back(rif.commit_pc);

        do_alloc = rif.alloc_valid && (mq.size() < 16) && !rif.rollback;
        rb_pos = rif.rollback ? find_pos(rif.rollback_tag) : -1;
        wb_pos = rif.wb_valid ? find_pos(rif.wb_tag) : -1;
        if (rb_pos >= 0 && wb_pos > rb_pos) wb_pos = -1;
        if (wb_pos >= 0) mq[wb_pos].done = 1'b1;
        if (rb_pos >= 0) begin
            while (mq.size() > rb_pos + 1) void'(mq.pop_back());
            m_tail = (int'(rif.rollback_tag) + 1) % 16;
        end
        if (exp_cv) void'(mq.pop_front());
        if (do_alloc) begin
            e.idx  = 4'(m_tail);
            e.rd   = rif.alloc_arch_rd;
            e.pdst = rif.alloc_pdst;
            e.old  = rif.alloc_old_pdst;
            e.wen  = rif.alloc_wen;
            e.pc   = rif.alloc_pc;
            e.done = 1'b0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        drive_alloc(1'b0);
        mq.delete();
        commit_log.delete();
        m_tail = 0;
        seq = 0;
        #2;
        check("rst_count", 32'(rif.count), 32'd0);
        check("rst_empty", 32'(rif.ROB_empty), 32'd1);
        check("rst_full", 32'(rif.ROB_full), 32'd0);
        check("rst_alloc_tag", 32'(rif.alloc_tag), 32'd0);
        check("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
        check("rst_commit_pc", rif.commit_pc, 32'd0);
        check("rst_commit_old_pdst", 32'(rif.commit_old_pdst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive_alloc(1'b1);
            tick();
        end
        drive_alloc(1'b0);
    endtask

    initial begin
        idle_inputs();
        drive_alloc(1'b0);

        // Reset mid-run with 5 valid entries, head done.
        do_reset();
        alloc_n(5);
        rif.wb_valid = 1'b1; rif.wb_tag = 4'd0;
        tick();
        rif.wb_valid = 1'b0;
        check("pre_rst_commit_valid", 32'(rif.commit_valid), 32'd1);
        do_reset();
        tick();

        // Fill to full, drop the 17th, then retire entry 0.
        for (int i = 0; i < 16; i++) begin
            check("fill_alloc_tag", 32'(rif.alloc_tag), 32'(i));
            drive_alloc(1'b1);
            tick();
        end
        check("fill_full", 32'(rif.ROB_full), 32'd1);
        drive_alloc(1'b1);
        tick();
        drive_alloc(1'b0);
        check("drop_count", 32'(rif.count), 32'd16);
        check("drop_alloc_tag", 32'(rif.alloc_tag), 32'd0);
        rif.wb_valid = 1'b1; rif.wb_tag = 4'd0;
        tick();
        rif.wb_valid = 1'b0;
        check("wb0_commit_valid", 32'(rif.commit_valid), 32'd1);
        check("wb0_commit_old_pdst", 32'(rif.commit_old_pdst), 32'd7);
        check("wb0_still_full", 32'(rif.ROB_full), 32'd1);
        tick();
        check("after_commit_full", 32'(rif.ROB_full), 32'd0);
        check("after_commit_count", 32'(rif.count), 32'd15);

        // Out-of-order writeback, in-order retirement.
        do_reset();
        alloc_n(4);
        rif.wb_valid = 1'b1;
        rif.wb_tag = 4'd3; tick();
        rif.wb_tag = 4'd1; tick();
        check("ooo_no_commit", 32'(rif.commit_valid), 32'd0);
        rif.wb_tag = 4'd0; tick();
        check("ooo_c0", rif.commit_pc, 32'h1000);
        rif.wb_tag = 4'd2; tick();
        rif.wb_valid = 1'b0;
        check("ooo_c1", rif.commit_pc, 32'h1004);
        tick();
        check("ooo_c2", rif.commit_pc, 32'h1008);
        tick();
        check("ooo_c3", rif.commit_pc, 32'h100c);
        tick();
        check("ooo_empty", 32'(rif.ROB_empty), 32'd1);
        exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100c};
        check("ooo_log_size", 32'(commit_log.size()), 32'(exp_q.size()));
        foreach (exp_q[k]) if (k < commit_log.size()) check("ooo_order", commit_log[k], exp_q[k]);

        // Rollback to tag 4 with a simultaneous alloc request.
        do_reset();
        alloc_n(10);
        drive_alloc(1'b1);
        rif.rollback = 1'b1; rif.rollback_tag = 4'd4;
        tick();
        drive_alloc(1'b0);
        rif.rollback = 1'b0;
        check("rb_count", 32'(rif.count), 32'd5);
        check("rb_alloc_tag", 32'(rif.alloc_tag), 32'd5);
        rif.wb_valid = 1'b1; rif.wb_tag = 4'd7;
        tick();
        rif.wb_valid = 1'b0;
        check("rb_wb_ignored_count", 32'(rif.count), 32'd5);
        check("rb_next_tag", 32'(rif.alloc_tag), 32'd5);
        alloc_n(3);
        check("rb_realloc_count", 32'(rif.count), 32'd8);
        tick();

        // Wrapped rollback with a same-cycle commit.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_alloc(1'b1);
            rif.wb_valid = (i > 0);
            rif.wb_tag = 4'(i - 1);
            tick();
        end
        drive_alloc(1'b0);
        rif.wb_valid = 1'b1; rif.wb_tag = 4'd13;
        tick();
        rif.wb_valid = 1'b0;
        for (int n = 0; n < 40 && mq.size() > 0; n++) tick();
        check("drain_done", 32'(mq.size()), 32'd0);
        check("wrap_head_tag", 32'(rif.alloc_tag), 32'd14);
        alloc_n(6);
        rif.wb_valid = 1'b1; rif.wb_tag = 4'd14;
        tick();
        rif.wb_valid = 1'b0;
        check("wrap_commit_valid", 32'(rif.commit_valid), 32'd1);
        check("wrap_commit_pc", rif.commit_pc, 32'h1038);
        rif.rollback = 1'b1; rif.rollback_tag = 4'd1;
        tick();
        rif.rollback = 1'b0;
        check("wrap_count", 32'(rif.count), 32'd3);
        check("wrap_alloc_tag", 32'(rif.alloc_tag), 32'd2);
        tick();

        // Full buffer: commit plus alloc refuses the alloc.
        do_reset();
        alloc_n(16);
        rif.wb_valid = 1'b1; rif.wb_tag = 4'd0;
        tick();
        rif.wb_valid = 1'b0;
        drive_alloc(1'b1);
        tick();
        check("full_refuse_count", 32'(rif.count), 32'd15);
        tick();
        drive_alloc(1'b0);
        check("full_accept_count", 32'(rif.count), 32'd16);
        check("full_again", 32'(rif.ROB_full), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the o3cpu back end.
- Allocates one entry per dispatched instruction at the rename/dispatch boundary and marks entries done from the writeback bus.
- Retires the oldest entry in program order, one per cycle, and frees its old physical register.
- Drives ROB_full into the hazard unit; consumes ROB_rollback plus the mispredicted branch tag to discard younger entries.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
IDX_W, 4, log2(DEPTH)
PREG_W, 6, physical register tag width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alloc_valid  input  1  dispatch request, already gated by RN_DP_Stall
alloc_arch_rd  input  5  architectural destination
alloc_pdst  input  PREG_W  newly mapped physical destination
alloc_old_pdst  input  PREG_W  previous mapping of alloc_arch_rd
alloc_wen  input  1  instruction writes a register
alloc_pc  input  32  instruction PC
alloc_tag  output  IDX_W  entry index the current request would receive (tail index)
ROB_full  output  1  count == DEPTH
ROB_empty  output  1  count == 0
count  output  IDX_W+1  valid entries
wb_valid  input  1  completion broadcast
wb_tag  input  IDX_W  entry completing
rollback  input  1  ROB_rollback from hazard unit
rollback_tag  input  IDX_W  entry of the mispredicted branch
commit_valid  output  1  head entry retires this cycle
commit_arch_rd  output  5  head arch rd
commit_pdst  output  PREG_W  head new pdst
commit_old_pdst  output  PREG_W  pdst returned to the free list
commit_wen  output  1  head writes a register
commit_pc  output  32  head PC

Behaviour:
- State:
  - head and tail pointers, IDX_W+1 bits each; the MSB is the wrap bit.
  - count = tail - head.
  - Per entry: valid, done, arch_rd, pdst, old_pdst, wen, pc.
- Reset (async, rst_n low):
  - head = tail = 0; all valid/done = 0.
  - Outputs: ROB_full = 0, ROB_empty = 1, count = 0, alloc_tag = 0, commit_valid = 0.
  - All commit_* fields = 0.
- Status outputs:
  - ROB_full, ROB_empty, count and alloc_tag are registered-state derived, with no combinational path from same-cycle inputs.
- Allocation:
  - Accepted iff alloc_valid && !ROB_full && !rollback.
  - On accept: entry[tail] is written with valid = 1, done = 0; tail += 1 at the edge.
  - alloc_valid while full, or during rollback, is dropped silently.
- Writeback:
  - If wb_valid && entry[wb_tag].valid, set done = 1 at the edge.
  - wb to an invalid entry is ignored.
  - wb to an entry being flushed in the same cycle is ignored.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, combinational from state.
  - commit_* fields are taken from entry[head] when commit_valid = 1, else 0.
  - On commit: clear entry[head].valid/done; head += 1 at the edge. At most one commit per cycle.
  - An entry whose done is set this edge commits no earlier than the next cycle (1-cycle wb-to-commit latency).
- Rollback (rollback = 1 and entry[rollback_tag].valid):
  - keep = ((rollback_tag - head[IDX_W-1:0]) mod DEPTH) + 1.
  - tail <= head + keep, with correct wrap bit.
  - Entries strictly younger than rollback_tag are cleared.
  - The branch entry itself is retained.
- Rollback with an invalid rollback_tag: ignored, no state change; allocation is still blocked that cycle.
- Simultaneous events:
  - Commit proceeds in a rollback cycle (head is older than or equal to the branch). count becomes keep - 1 if commit fires.
  - Commit and allocate in the same cycle on a full buffer: allocation is refused, because fullness is evaluated on pre-edge state.
  - Commit and allocate in the same cycle on a non-full buffer: both occur; count is unchanged.
- Wrap-around: pointer indices wrap modulo DEPTH. Full vs empty is distinguished by the wrap bit.

Test Plan:
- Reset mid-run with 5 entries valid -> next cycle count = 0, ROB_empty = 1, commit_valid = 0, alloc_tag = 0.
- 16 back-to-back allocs -> alloc_tag 0..15, ROB_full = 1 after the 16th; 17th alloc dropped with tail unchanged. wb tag 0 -> one cycle later commit_valid = 1, commit_old_pdst = entry 0's old_pdst, and ROB_full deasserts after that edge.
- Allocate tags 0..3; wb in order 3, 1, 0, 2 -> commits fire strictly in order 0, 1, 2, 3; entry 0 commits one cycle after wb 0, and entries 1–3 then commit on consecutive cycles.
- 10 entries (head = 0); rollback_tag = 4 while alloc_valid = 1 -> count = 5, tail = 5, alloc dropped; a later wb to tag 7 is ignored; next alloc receives tag 5.
- head = 14 with 6 entries (tags 14, 15, 0..3); entry 14 done; rollback_tag = 1 in the same cycle -> entry 14 commits, count = 3, tail index = 2 with the wrap bit toggled.
- Fill to 16, then in one cycle commit 1 entry and request alloc -> alloc refused, count = 15; next-cycle alloc accepted, count = 16.
